// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch stage and the pipeline
//   registers built from if_ex_reg.
//
//   Contents:
//     BUS_WIDTH         width of the address / instruction bus
//     NOP_INSTR         bubble instruction (addi x0,x0,0)
//     RESET_PC_DEFAULT  default program counter after reset
//     fetch_state_t     fetch controller states
//     if_ex_t           one IF/EX pipeline register entry
//     in_range()        legal-fetch-address test
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned BUS_WIDTH = 32;

    localparam logic [BUS_WIDTH-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [BUS_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [BUS_WIDTH-1:0] pc;
        logic [BUS_WIDTH-1:0] inst;
        logic                 valid;
    } if_ex_t;

    // A fetch address is legal when it is word aligned and the whole word
    // lies inside the memory. Unsigned compare, so huge addresses fail too.
    function automatic logic in_range(input logic [BUS_WIDTH-1:0] addr,
                                      input logic [BUS_WIDTH-1:0] imem_bytes);
        return (addr[1:0] == 2'b00) && (addr <= (imem_bytes - BUS_WIDTH'(4)));
    endfunction

endpackage : fetch_pkg

// File: rtl/fetch_stage_if_ex_reg.sv
// ----------------------------------------------------------------------------
// if_ex_reg
//   Pipeline register holding {pc, inst, valid}. Used for IF/EX and reused
//   for EX/WB.
//
//   Ports:
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset (loads a bubble)
//     hold_i   in   keep current contents (stall)
//     flush_i  in   load a bubble on the next edge; wins over hold_i
//     pc_i     in   incoming PC
//     inst_i   in   incoming instruction
//     valid_i  in   incoming valid flag
//     pc_o     out  registered PC
//     inst_o   out  registered instruction
//     valid_o  out  registered valid flag
// ----------------------------------------------------------------------------
module if_ex_reg
    import fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold_i,
    input  logic                 flush_i,
    input  logic [BUS_WIDTH-1:0] pc_i,
    input  logic [BUS_WIDTH-1:0] inst_i,
    input  logic                 valid_i,
    output logic [BUS_WIDTH-1:0] pc_o,
    output logic [BUS_WIDTH-1:0] inst_o,
    output logic                 valid_o
);

    localparam if_ex_t BUBBLE = '{pc: '0, inst: NOP_INSTR, valid: 1'b0};

    if_ex_t entry_q;
    if_ex_t entry_d;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        entry_d = '{pc: pc_i, inst: inst_i, valid: valid_i};
        if (flush_i) begin
            entry_d = BUBBLE;
        end else if (hold_i) begin
            entry_d = entry_q;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= BUBBLE;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign pc_o    = entry_q.pc;
    assign inst_o  = entry_q.inst;
    assign valid_o = entry_q.valid;

endmodule : if_ex_reg

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 3-stage pipeline. Owns the program
//   counter, presents it to the combinational instruction memory and
//   registers {pc, instr, valid} into the IF/EX register. Handles stalls,
//   redirects (branch/jump/trap/mret), the boot bubble and containment of
//   misaligned or out-of-range fetches.
//
//   Parameters:
//     RESET_PC    PC loaded at reset
//     IMEM_BYTES  instruction memory size in bytes
//
//   Ports:
//     clk               in   rising-edge clock
//     rst_n             in   asynchronous active-low reset
//     stall_i           in   hold PC and IF/EX
//     redirect_valid_i  in   redirect request; also flushes IF/EX
//     redirect_pc_i     in   redirect target byte address
//     imem_addr_o       out  byte address to instruction memory (= pc_q)
//     imem_inst_i       in   instruction word returned combinationally
//     if_pc_o           out  PC of the instruction in IF/EX
//     if_inst_o         out  instruction in IF/EX
//     if_valid_o        out  IF/EX holds a real instruction
//     fetch_fault_o     out  sticky fetch fault
// ----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [BUS_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned          IMEM_BYTES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 redirect_valid_i,
    input  logic [BUS_WIDTH-1:0] redirect_pc_i,
    output logic [BUS_WIDTH-1:0] imem_addr_o,
    input  logic [BUS_WIDTH-1:0] imem_inst_i,
    output logic [BUS_WIDTH-1:0] if_pc_o,
    output logic [BUS_WIDTH-1:0] if_inst_o,
    output logic                 if_valid_o,
    output logic                 fetch_fault_o
);

    localparam logic [BUS_WIDTH-1:0] MEM_BYTES = BUS_WIDTH'(IMEM_BYTES);

    fetch_state_t         state_q, state_d;
    logic [BUS_WIDTH-1:0] pc_q, pc_d;
    logic                 fault_q, fault_d;

    logic                 ifex_hold;
    logic                 ifex_flush;
    logic                 ifex_valid_in;
    logic [BUS_WIDTH-1:0] pc_plus4;
    logic                 redirect_ok;
    logic                 next_ok;

    assign pc_plus4    = pc_q + BUS_WIDTH'(4);
    assign redirect_ok = in_range(redirect_pc_i, MEM_BYTES);
    assign next_ok     = in_range(pc_plus4, MEM_BYTES);

    // ------------------------------------------------------------------
    // Next-state logic. IF/EX is steered via hold/flush; its data inputs
    // are always the current fetch {pc_q, imem_inst_i, 1}.
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fault_d       = fault_q;
        ifex_hold     = 1'b0;
        ifex_flush    = 1'b0;
        ifex_valid_in = 1'b1;

        unique case (state_q)
            // First edge after reset: memory output is not yet trusted for
            // the reset PC, so insert a bubble and ignore any redirect.
            BOOT: begin
                ifex_flush = 1'b1;
                state_d    = RUN;
            end

            RUN: begin
                if (redirect_valid_i) begin
                    // Redirect beats stall: the wrong-path fetch must die.
                    ifex_flush = 1'b1;
                    if (redirect_ok) begin
                        pc_d = redirect_pc_i;
                    end else begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end
                end else if (stall_i) begin
                    ifex_hold = 1'b1;
                end else begin
                    // The current word is delivered even if the following
                    // address is illegal; only the PC advance is blocked.
                    if (next_ok) begin
                        pc_d = pc_plus4;
                    end else begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end
                end
            end

            FAULT: begin
                // Nothing is fetched until a legal redirect (trap vector)
                // arrives; stall has no effect here.
                ifex_flush = 1'b1;
                if (redirect_valid_i && redirect_ok) begin
                    pc_d    = redirect_pc_i;
                    fault_d = 1'b0;
                    state_d = RUN;
                end
            end

            default: begin
                ifex_flush = 1'b1;
                state_d    = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    if_ex_reg u_if_ex_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (ifex_hold),
        .flush_i (ifex_flush),
        .pc_i    (pc_q),
        .inst_i  (imem_inst_i),
        .valid_i (ifex_valid_in),
        .pc_o    (if_pc_o),
        .inst_o  (if_inst_o),
        .valid_o (if_valid_o)
    );

    assign imem_addr_o   = pc_q;
    assign fetch_fault_o = fault_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage: directed scenarios followed by
//   randomized stall/redirect/reset traffic, compared against a behavioural
//   model of the fetch rules.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int unsigned MEM_BYTES = 1024;
    localparam int unsigned MEM_WORDS = MEM_BYTES / 4;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_inst_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        fetch_fault_o;

    logic [31:0] mem [MEM_WORDS];

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_booting;
    bit          m_faulted;
    logic [31:0] m_pc;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    bit          e_valid;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (MEM_BYTES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_addr_o      (imem_addr_o),
        .imem_inst_i      (imem_inst_i),
        .if_pc_o          (if_pc_o),
        .if_inst_o        (if_inst_o),
        .if_valid_o       (if_valid_o),
        .fetch_fault_o    (fetch_fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory
    assign imem_inst_i = (imem_addr_o < MEM_BYTES) ? mem[imem_addr_o[9:2]] : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a <= MEM_BYTES - 4);
    endfunction

    task automatic model_reset();
        m_booting = 1'b1;
        m_faulted = 1'b0;
        m_pc      = 32'h0;
        e_pc      = 32'h0;
        e_inst    = NOP;
        e_valid   = 1'b0;
    endtask

    task automatic bubble();
        e_pc    = 32'h0;
        e_inst  = NOP;
        e_valid = 1'b0;
    endtask

    // One rising edge of the fetch rules.
    task automatic model_step(input bit stall, input bit redir, input logic [31:0] tgt);
        logic [31:0] nxt;
        if (m_booting) begin
            bubble();
            m_booting = 1'b0;
        end else if (m_faulted) begin
            bubble();
            if (redir && legal(tgt)) begin
                m_pc      = tgt;
                m_faulted = 1'b0;
            end
        end else if (redir) begin
            bubble();
            if (legal(tgt)) m_pc = tgt;
            else            m_faulted = 1'b1;
        end else if (!stall) begin
            e_pc    = m_pc;
            e_inst  = mem[m_pc / 4];
            e_valid = 1'b1;
            nxt     = m_pc + 32'd4;
            if (legal(nxt)) m_pc = nxt;
            else            m_faulted = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  imem_addr_o, m_pc);
        check({tag, ".pc"},    if_pc_o, e_pc);
        check({tag, ".inst"},  if_inst_o, e_inst);
        check({tag, ".valid"}, {31'b0, if_valid_o}, {31'b0, e_valid});
        check({tag, ".fault"}, {31'b0, fetch_fault_o}, {31'b0, m_faulted});
    endtask

    // Drive inputs, clock once, update the model, then sample 1 time unit
    // after the edge.
    task automatic cycle(input string tag, input bit stall, input bit redir,
                         input logic [31:0] tgt);
        stall_i          = stall;
        redirect_valid_i = redir;
        redirect_pc_i    = tgt;
        @(posedge clk);
        model_step(stall, redir, tgt);
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges, check outputs respond without a clock,
    // also across one edge while held, then release on a falling edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_target();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2, 3, 4, 5: return 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
            6:                return 32'h3F0 + 32'($urandom_range(0, 3)) * 4;
            7:                return (32'($urandom_range(0, MEM_WORDS - 1)) * 4) | 32'($urandom_range(1, 3));
            8:                return 32'h400 + 32'($urandom_range(0, 63)) * 4;
            default:          return $urandom;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;

        rst_n            = 1'b0;
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Boot bubble, then sequential fetches; a redirect during BOOT is ignored.
        cycle("boot", 1'b0, 1'b1, 32'h0000_0080);
        cycle("fetch0", 1'b0, 1'b0, 32'h0);
        cycle("fetch1", 1'b0, 1'b0, 32'h0);

        // Stall at pc 8 for three cycles, then release.
        for (int i = 0; i < 3; i++) cycle("stall", 1'b1, 1'b0, 32'h0);
        cycle("unstall", 1'b0, 1'b0, 32'h0);

        // Redirect beats stall.
        cycle("redir_stall", 1'b1, 1'b1, 32'h0000_0040);
        cycle("after_redir", 1'b0, 1'b0, 32'h0);

        // Misaligned redirect faults; stall ignored; legal redirect recovers.
        cycle("redir_mis", 1'b0, 1'b1, 32'h0000_0042);
        cycle("fault_stall", 1'b1, 1'b0, 32'h0);
        cycle("fault_idle", 1'b0, 1'b0, 32'h0);
        cycle("fault_bad", 1'b0, 1'b1, 32'h0000_0400);
        cycle("recover", 1'b0, 1'b1, 32'h0000_0010);
        cycle("recovered", 1'b0, 1'b0, 32'h0);

        // Run off the end of memory.
        cycle("to_end", 1'b0, 1'b1, 32'h0000_03F0);
        for (int i = 0; i < 6; i++) cycle("end_run", 1'b0, 1'b0, 32'h0);

        // Asynchronous reset mid-stream restarts with the boot bubble.
        cycle("pre_rst", 1'b0, 1'b1, 32'h0000_0020);
        cycle("pre_rst2", 1'b0, 1'b0, 32'h0);
        async_reset("mid");
        cycle("reboot", 1'b0, 1'b0, 32'h0);
        cycle("refetch", 1'b0, 1'b0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          st;
            bit          rd;
            logic [31:0] tg;
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 9) == 0);
            tg = rand_target();
            if ($urandom_range(0, 499) == 0) async_reset("rand");
            cycle("rand", st, rd, tg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_stage
